// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider ratio controller.
package div_ctrl_pkg;

    localparam int DEF_RATIO_W     = 8;
    localparam int DEF_TIMEOUT_CYC = 512;
    localparam int RESET_RATIO     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } state_t;

endpackage

// File: rtl/div_edge_det.sv
// Brings the fed-back divided clock into the reference domain and flags its rising edges.
module div_edge_det (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_d,
    output logic o_rise
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= I_d;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign o_rise = sync_p1 && !prev_p2;

endmodule

// File: rtl/div_ratio_ctrl.sv
// Glitch-free ratio update controller for an integer clock divider.
// Optional PEND timeout is enabled with the DIV_CTRL_TIMEOUT_EN macro.
import div_ctrl_pkg::*;

module div_ratio_ctrl #(
    parameter int RATIO_W     = DEF_RATIO_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               I_ref_clk,
    input  logic               I_rst,
    input  logic               I_enable,
    input  logic               I_cfg_valid,
    input  logic [RATIO_W-1:0] I_cfg_ratio,
    input  logic               I_div_clk,
    output logic               o_cfg_ready,
    output logic [RATIO_W-1:0] o_div_ratio,
    output logic               o_clk_en,
    output logic               o_bypass,
    output logic               o_err,
    output logic               o_busy
);

    state_t             state;
    state_t             state_nxt;
    logic               err_nxt;
    logic               div_rise;
    logic               accept;
    logic               ratio_zero;
    logic               timeout_hit;
    logic [RATIO_W-1:0] held_ratio;

    div_edge_det u_edge (
        .I_clk  (I_ref_clk),
        .I_rst  (I_rst),
        .I_d    (I_div_clk),
        .o_rise (div_rise)
    );

    assign accept      = I_cfg_valid && (state == IDLE);
    assign ratio_zero  = (I_cfg_ratio == '0);
    assign o_cfg_ready = (state == IDLE);
    assign o_busy      = (state != IDLE);

`ifdef DIV_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    // Counts consecutive PEND cycles; any exit from PEND restarts it.
    always_ff @(posedge I_ref_clk) begin
        if (I_rst) begin
            to_cnt <= '0;
        end else if (state == PEND && state_nxt == PEND) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (ratio_zero) begin
                        err_nxt = 1'b1;
                    end else if (o_clk_en) begin
                        state_nxt = PEND;
                    end else begin
                        state_nxt = APPLY;
                    end
                end
            end
            PEND: begin
                // A stopped divider has no edge to wait for, so apply immediately.
                if (div_rise || !o_clk_en) begin
                    state_nxt = APPLY;
                end else if (timeout_hit) begin
                    state_nxt = APPLY;
                    err_nxt   = 1'b1;
                end
            end
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_ref_clk) begin
        if (I_rst) begin
            state       <= IDLE;
            o_div_ratio <= RATIO_W'(RESET_RATIO);
            o_clk_en    <= 1'b0;
            o_bypass    <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state    <= state_nxt;
            o_clk_en <= I_enable;
            o_err    <= err_nxt;
            if (state == APPLY) begin
                o_div_ratio <= held_ratio;
                o_bypass    <= (held_ratio == RATIO_W'(1));
            end
        end
    end

    // Holding register needs no reset: it is only read in APPLY, which always follows a fresh capture.
    always_ff @(posedge I_ref_clk) begin
        if (accept && !ratio_zero) begin
            held_ratio <= I_cfg_ratio;
        end
    end

endmodule

// File: doc/div_ratio_ctrl.md
DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

Interface
REQ-001 Parameter: RATIO_W, 8, width of the ratio bus to the integer divider.
REQ-002 Parameter: TIMEOUT_CYC, 512, max ref cycles to wait for a divided-clock edge (used only with DIV_CTRL_TIMEOUT_EN).
REQ-003 Port: I_ref_clk  in  1  single reference clock; all logic on its rising edge.
REQ-004 Port: I_rst  in  1  reset, synchronous, active-high.
REQ-005 Port: I_enable  in  1  software enable for the downstream divider.
REQ-006 Port: I_cfg_valid  in  1  new ratio offered.
REQ-007 Port: I_cfg_ratio  in  RATIO_W  requested divide ratio.
REQ-008 Port: I_div_clk  in  1  divided clock fed back from the divider output.
REQ-009 Port: o_cfg_ready  out  1  block can accept a ratio.
REQ-010 Port: o_div_ratio  out  RATIO_W  ratio driven to the divider, registered.
REQ-011 Port: o_clk_en  out  1  clock enable to the divider, registered.
REQ-012 Port: o_bypass  out  1  high when the applied ratio is 1; downstream muxes I_ref_clk through.
REQ-013 Port: o_err  out  1  one-cycle pulse on rejected config.
REQ-014 Port: o_busy  out  1  high while a ratio change is pending or applying.

Function
REQ-015 FSM states: IDLE, PEND, APPLY; o_cfg_ready SHALL be high only in IDLE.
REQ-016 Transfer occurs on the cycle I_cfg_valid && o_cfg_ready; I_cfg_ratio captured into a holding register.
REQ-017 Ratio 0 SHALL be rejected: o_err pulses the next cycle, state stays IDLE, outputs unchanged.
REQ-018 Accepted ratio with o_clk_en low: IDLE -> APPLY next cycle.
REQ-019 Accepted ratio with o_clk_en high: IDLE -> PEND; wait for a rising edge of I_div_clk.
REQ-020 I_div_clk SHALL be registered twice; edge = stage2 high and stage3 (previous) low.
REQ-021 PEND -> APPLY on detected edge, or when o_clk_en is low.
REQ-022 APPLY lasts exactly one cycle: o_div_ratio <= held ratio, o_bypass <= (held ratio == 1); then IDLE.
REQ-023 Latency with o_clk_en low: accept at cycle N, o_div_ratio new value visible at N+2, o_cfg_ready high at N+2.
REQ-024 o_clk_en SHALL follow I_enable with one-cycle latency, independent of FSM state.
REQ-025 o_busy = (state != IDLE).
REQ-026 Rewriting the currently applied ratio SHALL run the full handshake with no output glitch.
REQ-027 I_cfg_valid while not ready SHALL be ignored; no queuing.

Reset
REQ-028 On I_rst: state IDLE, o_div_ratio = 2, o_clk_en = 0, o_bypass = 0, o_err = 0, o_busy = 0, o_cfg_ready = 1, edge-sync flops = 0.
REQ-029 Reset in PEND or APPLY SHALL discard the held ratio; o_div_ratio returns to 2.

Configuration
REQ-030 Macro DIV_CTRL_TIMEOUT_EN defined: a counter runs in PEND; at TIMEOUT_CYC cycles without an edge, the FSM goes to APPLY and o_err pulses one cycle; the counter clears on leaving PEND.
REQ-031 Macro undefined: no counter; PEND waits indefinitely for an edge or o_clk_en low.

Structure
REQ-032 Shared package div_ctrl_pkg: state enum (IDLE/PEND/APPLY), RESET_RATIO = 2, default RATIO_W and TIMEOUT_CYC constants.
REQ-033 One sub-module, div_edge_det: 2-flop sync plus previous-value flop, output rising-edge pulse.

Verification
REQ-034 Reset, then I_enable=0, offer ratio 6 -> ready at accept, o_div_ratio = 6 two cycles later, o_bypass = 0.
REQ-035 I_enable=1 running at ratio 4, offer ratio 7 -> o_busy high, o_div_ratio stays 4 until the cycle after a detected I_div_clk rising edge, then 7.
REQ-036 Offer ratio 0 -> o_err single pulse, o_div_ratio unchanged, o_cfg_ready stays high.
REQ-037 Offer ratio 1 with I_enable=0 -> o_bypass = 1 at N+2; then offer 3 -> o_bypass = 0.
REQ-038 With macro defined, I_enable=1, I_div_clk held low, offer 5 -> apply after 512 PEND cycles with o_err pulse; without macro -> o_busy stays high.
REQ-039 Assert I_rst in PEND -> next cycle o_div_ratio = 2, o_busy = 0, o_cfg_ready = 1.
